// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared forward-select encodings and sequencer state type for pipe_ctrl
package pipe_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    DRAIN    = 2'b10,
    HALT     = 2'b11
  } state_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - one operand's forward select from M/W destination matches (M wins over W)
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_SIZE = 5
) (
  input  logic [REG_SIZE-1:0] raddr,
  input  logic                use_rs,
  input  logic [REG_SIZE-1:0] wreg_m,
  input  logic                wen_m,
  input  logic [REG_SIZE-1:0] wreg_w,
  input  logic                wen_w,
  output logic [1:0]          sel
);

  logic hit_m;
  logic hit_w;

  // x0 is never a forwarding source: it always reads as zero.
  assign hit_m = use_rs & wen_m & (wreg_m != '0) & (wreg_m == raddr);
  assign hit_w = use_rs & wen_w & (wreg_w != '0) & (wreg_w == raddr);

  always_comb begin
    sel = FWD_NONE;
    if (hit_m)      sel = FWD_M;
    else if (hit_w) sel = FWD_W;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer/hazard controller; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_SIZE = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  input  logic                controllchangeD,
  input  logic [REG_SIZE-1:0] raddr1E,
  input  logic [REG_SIZE-1:0] raddr2E,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                regWriteE,
  input  logic                regWriteM,
  input  logic                regWriteW,
  input  logic                mem2regE,
  input  logic                mem2regM,
  input  logic                memWriteM,
  input  logic                validE,
  input  logic                validM,
  input  logic                validW,
  input  logic                finishE,
  input  logic                finishW,
  input  logic                dmem_ack,
  output logic                enF,
  output logic                enD,
  output logic                enE,
  output logic                enM,
  output logic                enW,
  output logic                flushD,
  output logic                flushE,
  output logic [1:0]          forward1D,
  output logic [1:0]          forward2D,
  output logic [1:0]          forward1E,
  output logic [1:0]          forward2E,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]    stallCnt,
  output logic [CNT_W-1:0]    flushCnt,
`endif
  output logic                halt
);

  state_t state;
  logic   halt_q;

  logic live_e, live_m, live_w, fwd_m_ok;
  logic e1, e2, m1, m2;
  logic loaduse, brhaz, dstall;
  logic memreq, memstall, finish_e, draining;
  logic stall_evt;
  logic [1:0] f1d, f2d, f1e, f2e;

  assign live_e   = regWriteE & validE & (writeRegE != '0);
  assign live_m   = regWriteM & validM & (writeRegM != '0);
  assign live_w   = regWriteW & validW;
  assign fwd_m_ok = regWriteM & validM & ~mem2regM;

  assign e1 = live_e & (writeRegE == raddr1D);
  assign e2 = live_e & (writeRegE == raddr2D);
  assign m1 = live_m & (writeRegM == raddr1D);
  assign m2 = live_m & (writeRegM == raddr2D);

  // Load-use blocks even unused operands; branch compares in D also wait on ALU results in E.
  assign loaduse = mem2regE & (e1 | e2);
  assign brhaz   = (useRs1D & (e1 | (mem2regM & m1))) |
                   (useRs2D & (e2 | (mem2regM & m2)));
  assign dstall  = loaduse | brhaz;

  assign memreq   = validM & (mem2regM | memWriteM);
  assign memstall = memreq & ~dmem_ack;
  assign finish_e = finishE & validE;
  assign draining = (state == DRAIN) | (((state == RUN) | (state == MEM_WAIT)) & finish_e);

  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd1d (
    .raddr(raddr1D), .use_rs(useRs1D), .wreg_m(writeRegM), .wen_m(fwd_m_ok),
    .wreg_w(writeRegW), .wen_w(1'b0), .sel(f1d)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd2d (
    .raddr(raddr2D), .use_rs(useRs2D), .wreg_m(writeRegM), .wen_m(fwd_m_ok),
    .wreg_w(writeRegW), .wen_w(1'b0), .sel(f2d)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd1e (
    .raddr(raddr1E), .use_rs(1'b1), .wreg_m(writeRegM), .wen_m(fwd_m_ok),
    .wreg_w(writeRegW), .wen_w(live_w), .sel(f1e)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd2e (
    .raddr(raddr2E), .use_rs(1'b1), .wreg_m(writeRegM), .wen_m(fwd_m_ok),
    .wreg_w(writeRegW), .wen_w(live_w), .sel(f2e)
  );

  always_comb begin
    enF       = 1'b1;
    enD       = 1'b1;
    enE       = 1'b1;
    enM       = 1'b1;
    enW       = 1'b1;
    flushD    = 1'b0;
    flushE    = 1'b0;
    stall_evt = 1'b0;
    forward1D = f1d;
    forward2D = f2d;
    forward1E = f1e;
    forward2E = f2e;
    if (!reset) begin
      {enF, enD, enE, enM, enW} = '0;
      forward1D = FWD_NONE;
      forward2D = FWD_NONE;
      forward1E = FWD_NONE;
      forward2E = FWD_NONE;
    end else if (state == HALT) begin
      {enF, enD, enE, enM, enW} = '0;
    end else if (memstall) begin
      {enF, enD, enE, enM, enW} = '0;
      stall_evt = 1'b1;
    end else if (draining) begin
      enF    = 1'b0;
      enD    = 1'b0;
      flushE = 1'b1;
    end else if (dstall) begin
      enF       = 1'b0;
      enD       = 1'b0;
      flushE    = 1'b1;
      stall_evt = 1'b1;
    end else begin
      flushD = controllchangeD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memstall)      state <= MEM_WAIT;
          else if (finish_e) state <= DRAIN;
        end
        MEM_WAIT: begin
          // Completion cycle advances like RUN, so a finish sitting in E must start the drain here.
          if (!memstall) state <= finish_e ? DRAIN : RUN;
        end
        DRAIN: begin
          if (finishW & validW) begin
            state  <= HALT;
            halt_q <= 1'b1;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign halt = halt_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall_evt) stallCnt <= stallCnt + 1'b1;
      if (flushD)    flushCnt <= flushCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed-vector self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raddr1D, raddr2D, raddr1E, raddr2E, writeRegE, writeRegM, writeRegW;
  logic       useRs1D, useRs2D, controllchangeD;
  logic       regWriteE, regWriteM, regWriteW, mem2regE, mem2regM, memWriteM;
  logic       validE, validM, validW, finishE, finishW, dmem_ack;
  logic       enF, enD, enE, enM, enW, flushD, flushE, halt;
  logic [1:0] forward1D, forward2D, forward1E, forward2E;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt, flushCnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] env;
  assign env = {enF, enD, enE, enM, enW};

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_SIZE(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .raddr1D(raddr1D), .raddr2D(raddr2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .controllchangeD(controllchangeD), .raddr1E(raddr1E), .raddr2E(raddr2E),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .mem2regE(mem2regE), .mem2regM(mem2regM), .memWriteM(memWriteM),
    .validE(validE), .validM(validM), .validW(validW),
    .finishE(finishE), .finishW(finishW), .dmem_ack(dmem_ack),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .flushD(flushD), .flushE(flushE),
    .forward1D(forward1D), .forward2D(forward2D),
    .forward1E(forward1E), .forward2E(forward2E),
`ifdef PIPE_CTRL_PERF_EN
    .stallCnt(stallCnt), .flushCnt(flushCnt),
`endif
    .halt(halt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    raddr1D = 0; raddr2D = 0; raddr1E = 0; raddr2E = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    useRs1D = 0; useRs2D = 0; controllchangeD = 0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0;
    mem2regE = 0; mem2regM = 0; memWriteM = 0;
    validE = 0; validM = 0; validW = 0;
    finishE = 0; finishW = 0; dmem_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loaduse();
    mem2regE = 1; regWriteE = 1; validE = 1; writeRegE = 5;
    raddr1D = 5; raddr2D = 1;
  endtask

  initial begin
    idle();
    reset = 0;
    #2;
    regWriteM = 1; validM = 1; writeRegM = 4; raddr1E = 4;
    #1;
    chk("rst_en", env, 5'b00000);
    chk("rst_fwd1E", forward1E, 2'b00);
    chk("rst_flushE", flushE, 0);
    chk("rst_halt", halt, 0);

    cyc(); idle(); reset = 1; #1;
    chk("run_en", env, 5'b11111);
    chk("run_flushD", flushD, 0);

    // lw x5 in E, add x6,x5,x1 in D
    cyc(); idle(); set_loaduse(); #1;
    chk("lu_en", env, 5'b00111);
    chk("lu_flushE", flushE, 1);
    chk("lu_flushD", flushD, 0);
    cyc(); idle(); regWriteW = 1; validW = 1; writeRegW = 5; raddr1E = 5; raddr2E = 1; #1;
    chk("lu_fwd1E", forward1E, 2'b10);
    chk("lu_fwd2E", forward2E, 2'b00);
    chk("lu_after_en", env, 5'b11111);
    // load into x0 never stalls
    cyc(); idle(); set_loaduse(); writeRegE = 0; raddr1D = 0; #1;
    chk("lu_x0_en", env, 5'b11111);

    // add x3 in M, beq x3,x4 in D
    cyc(); idle(); regWriteM = 1; validM = 1; writeRegM = 3;
    raddr1D = 3; raddr2D = 4; useRs1D = 1; useRs2D = 1; #1;
    chk("br_fwd1D", forward1D, 2'b01);
    chk("br_fwd2D", forward2D, 2'b00);
    chk("br_en", env, 5'b11111);
    mem2regM = 1; dmem_ack = 1; #1;
    chk("brlw_fwd1D", forward1D, 2'b00);
    chk("brlw_en", env, 5'b00111);
    chk("brlw_flushE", flushE, 1);
    useRs1D = 0; #1;
    chk("brlw_nouse_en", env, 5'b11111);

    // E forwarding: M beats W, x0 destination ignored
    cyc(); idle(); regWriteM = 1; validM = 1; writeRegM = 7;
    regWriteW = 1; validW = 1; writeRegW = 7; raddr2E = 7; raddr1E = 3; #1;
    chk("fe_mw", forward2E, 2'b01);
    chk("fe_other", forward1E, 2'b00);
    writeRegM = 0; #1;
    chk("fe_m0", forward2E, 2'b10);
    writeRegW = 0; #1;
    chk("fe_both0", forward2E, 2'b00);
    writeRegM = 7; writeRegW = 7; mem2regM = 1; dmem_ack = 1; #1;
    chk("fe_ldm", forward2E, 2'b10);

    // store in M, ack low 3 cycles
    cyc(); idle(); validM = 1; memWriteM = 1; controllchangeD = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_en", env, 5'b00000);
      chk("mw_flushD", flushD, 0);
      cyc();
    end
    dmem_ack = 1; #1;
    chk("mw_ack_en", env, 5'b11111);
    chk("mw_ack_flushD", flushD, 1);
    cyc(); idle(); #1;
    chk("mw_run_en", env, 5'b11111);
    // same-cycle ack: zero stall
    validM = 1; mem2regM = 1; dmem_ack = 1; #1;
    chk("ack0_en", env, 5'b11111);

    // taken jal in D while stalled
    cyc(); idle(); set_loaduse(); controllchangeD = 1; #1;
    chk("jal_stall_flushD", flushD, 0);
    cyc(); idle(); controllchangeD = 1; #1;
    chk("jal_flushD", flushD, 1);
    chk("jal_en", env, 5'b11111);
    cyc(); idle(); #1;
    chk("jal_done_flushD", flushD, 0);

    // finish drain then halt
    cyc(); idle(); validE = 1; finishE = 1; #1;
    chk("fin_en", env, 5'b00111);
    chk("fin_flushE", flushE, 1);
    cyc(); idle(); #1;
    chk("drain_en", env, 5'b00111);
    cyc(); idle(); validM = 1; memWriteM = 1; #1;
    chk("drain_mw_en", env, 5'b00000);
    cyc(); idle(); validW = 1; finishW = 1; #1;
    chk("drain_w_halt", halt, 0);
    chk("drain_w_en", env, 5'b00111);
    cyc(); idle(); #1;
    chk("halt", halt, 1);
    chk("halt_en", env, 5'b00000);
    cyc(); controllchangeD = 1; #1;
    chk("halt_sticky", halt, 1);
    chk("halt_flushD", flushD, 0);
    reset = 0; #1;
    chk("halt_rst", halt, 0);
    cyc(); idle(); reset = 1; #1;
    chk("halt_rerun_en", env, 5'b11111);

    // reset mid-drain
    cyc(); idle(); validE = 1; finishE = 1; #1;
    chk("fin2_en", env, 5'b00111);
    cyc(); idle(); #1;
    chk("drain2_en", env, 5'b00111);
    reset = 0; #1;
    chk("drain_rst_en", env, 5'b00000);
    chk("drain_rst_halt", halt, 0);
    cyc(); reset = 1; #1;
    chk("post_rst_en", env, 5'b11111);
    chk("post_rst_flushE", flushE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
